// File: rtl/cam_capture_ds.sv
// OV7670 capture: registers the camera pins, pairs bytes into pixels, converts to RGB332
// (RGB565, YUYV luma or colour bars), decimates by powers of two and emits clipped linear writes.
module cam_capture_ds #(
   parameter int WIDTH     = 176,
   parameter int HEIGHT    = 144,
   parameter int ADDR_W    = 15,
   parameter int XDEC_LOG2 = 0,
   parameter int YDEC_LOG2 = 0
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [7:0]        CAMERA_IN,
   input  logic              HREF,
   input  logic              VSYNC,
   input  logic [1:0]        MODE,
   input  logic              CAPTURE_EN,
   input  logic              CLR_OVF,
   output logic              W_EN,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        PIXEL_OUT,
   output logic              FRAME_DONE,
   output logic              BUSY,
   output logic              OVF
);
   localparam int XW      = $clog2(WIDTH + 1);
   localparam int YW      = $clog2(HEIGHT + 1);
   localparam int BAR_LEN = ((WIDTH >> 3) > 0) ? (WIDTH >> 3) : 1;
   localparam int BW      = $clog2(BAR_LEN + 1);
   localparam logic [XW-1:0]     X_MAX     = XW'(WIDTH);
   localparam logic [YW-1:0]     Y_MAX     = YW'(HEIGHT);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);
   localparam logic [BW-1:0]     BAR_LAST  = BW'(BAR_LEN - 1);
   localparam logic [15:0]       X_MASK    = 16'((1 << XDEC_LOG2) - 1);
   localparam logic [15:0]       Y_MASK    = 16'((1 << YDEC_LOG2) - 1);

   typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE, SKIP} state_t;
   state_t state;

   logic              vs_r, vs_p, href_r, href_p, phase;
   logic [7:0]        data_r;
   logic [5:0]        byte_hi;      // only the first-byte bits any mode consumes
   logic [1:0]        mode_l;
   logic [15:0]       cam_px, cam_ln;
   logic [XW-1:0]     x;
   logic [YW-1:0]     y;
   logic [ADDR_W-1:0] line_base;
   logic              line_wrote, frame_wrote;
   logic [3:0]        bar_idx;
   logic [BW-1:0]     bar_cnt;

   logic       vs_rise, vs_fall, href_fall, in_frame, pix_valid, keep, fits;
   logic [7:0] bar_color, pix_val;

   always_comb begin
      vs_rise   = vs_r & ~vs_p;
      vs_fall   = ~vs_r & vs_p;
      href_fall = ~href_r & href_p;
      in_frame  = (state == ACTIVE) && !vs_r;
      pix_valid = in_frame && href_r && phase;
      keep      = ((cam_px & X_MASK) == 16'd0) && ((cam_ln & Y_MASK) == 16'd0);
      fits      = (x < X_MAX) && (y < Y_MAX);
      case (bar_idx)
         4'd0:    bar_color = 8'hFF;
         4'd1:    bar_color = 8'hFC;
         4'd2:    bar_color = 8'h1F;
         4'd3:    bar_color = 8'h1C;
         4'd4:    bar_color = 8'hE3;
         4'd5:    bar_color = 8'hE0;
         4'd6:    bar_color = 8'h03;
         default: bar_color = 8'h00;
      endcase
      case (mode_l)
         2'd1:    pix_val = {byte_hi[5:3], byte_hi[5:3], byte_hi[5:4]};
         2'd2:    pix_val = bar_color;
         default: pix_val = {byte_hi[5:3], byte_hi[2:0], data_r[4:3]};
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state <= WAIT_VS;
         vs_r <= 1'b0; vs_p <= 1'b0; href_r <= 1'b0; href_p <= 1'b0; phase <= 1'b0;
         data_r <= '0; byte_hi <= '0; mode_l <= '0;
         cam_px <= '0; cam_ln <= '0; x <= '0; y <= '0; line_base <= '0;
         line_wrote <= 1'b0; frame_wrote <= 1'b0; bar_idx <= '0; bar_cnt <= '0;
         W_EN <= 1'b0; W_ADDR <= '0; PIXEL_OUT <= '0; FRAME_DONE <= 1'b0; BUSY <= 1'b0; OVF <= 1'b0;
      end else begin
         vs_r   <= VSYNC;
         href_r <= HREF;
         data_r <= CAMERA_IN;
         vs_p   <= vs_r;
         href_p <= href_r;
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
         phase <= href_r ? ~phase : 1'b0;
         if (href_r && !phase)
            byte_hi <= {data_r[7:5], data_r[2:0]};
         if (CLR_OVF)
            OVF <= 1'b0;

         if (!href_r) begin
            cam_px <= '0; x <= '0; bar_idx <= '0; bar_cnt <= '0; line_wrote <= 1'b0;
         end else if (pix_valid) begin
            cam_px <= cam_px + 16'd1;
            if (keep) begin
               if (fits) begin
                  W_EN        <= 1'b1;
                  W_ADDR      <= line_base + ADDR_W'(x);
                  PIXEL_OUT   <= pix_val;
                  x           <= x + XW'(1);
                  line_wrote  <= 1'b1;
                  frame_wrote <= 1'b1;
                  if (bar_cnt == BAR_LAST) begin
                     bar_cnt <= '0;
                     if (bar_idx != 4'd8)
                        bar_idx <= bar_idx + 4'd1;
                  end else begin
                     bar_cnt <= bar_cnt + BW'(1);
                  end
               end else begin
                  OVF <= 1'b1;   // overrides a same-cycle CLR_OVF
               end
            end
         end

         case (state)
            WAIT_VS: if (vs_r) state <= VBLANK;
            VBLANK: begin
               cam_ln <= '0; y <= '0; line_base <= '0; frame_wrote <= 1'b0;
               cam_px <= '0; x <= '0; bar_idx <= '0; bar_cnt <= '0;
               if (vs_fall) begin
                  mode_l <= MODE;
                  state  <= CAPTURE_EN ? ACTIVE : SKIP;
                  BUSY   <= CAPTURE_EN;
               end
            end
            ACTIVE: begin
               if (vs_rise) begin
                  state      <= VBLANK;
                  BUSY       <= 1'b0;
                  FRAME_DONE <= frame_wrote;
               end else if (href_fall) begin
                  cam_ln <= cam_ln + 16'd1;
                  if (line_wrote) begin
                     y         <= y + YW'(1);
                     line_base <= line_base + LINE_STEP;
                  end
               end
            end
            default: if (vs_rise) state <= VBLANK;
         endcase
      end
   end
endmodule

// File: tb/tb_cam_capture_ds.sv
// Bench for cam_capture_ds: two instances (full-rate 16x4 and 2x2-decimated 8x4) share the pins;
// a frame-level reference model fills per-instance scoreboards that a negedge monitor drains.
module tb_cam_capture_ds;
   logic       clk = 1'b0;
   logic       rst, href, vsync, cap_en, clr_ovf;
   logic [7:0] cam;
   logic [1:0] mode;
   always #5 clk = ~clk;

   logic       we_a, fd_a, busy_a, ovf_a, we_b, fd_b, busy_b, ovf_b;
   logic [5:0] addr_a;
   logic [4:0] addr_b;
   logic [7:0] pix_a, pix_b;

   cam_capture_ds #(.WIDTH(16), .HEIGHT(4), .ADDR_W(6), .XDEC_LOG2(0), .YDEC_LOG2(0)) dut_a (
      .CLOCK(clk), .RESET(rst), .CAMERA_IN(cam), .HREF(href), .VSYNC(vsync), .MODE(mode),
      .CAPTURE_EN(cap_en), .CLR_OVF(clr_ovf), .W_EN(we_a), .W_ADDR(addr_a), .PIXEL_OUT(pix_a),
      .FRAME_DONE(fd_a), .BUSY(busy_a), .OVF(ovf_a));
   cam_capture_ds #(.WIDTH(8), .HEIGHT(4), .ADDR_W(5), .XDEC_LOG2(1), .YDEC_LOG2(1)) dut_b (
      .CLOCK(clk), .RESET(rst), .CAMERA_IN(cam), .HREF(href), .VSYNC(vsync), .MODE(mode),
      .CAPTURE_EN(cap_en), .CLR_OVF(clr_ovf), .W_EN(we_b), .W_ADDR(addr_b), .PIXEL_OUT(pix_b),
      .FRAME_DONE(fd_b), .BUSY(busy_b), .OVF(ovf_b));

   typedef struct {int addr; int data;} exp_t;
   exp_t qa[$], qb[$];
   int   n_tests = 0, n_fail = 0;
   int   fd_cnt[2] = '{0, 0};
   int   fd_exp[2] = '{0, 0};
   logic [7:0] fb[8][48];
   int   lens[8];
   logic [7:0] bars[8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (we_a) begin
         if (qa.size() == 0) check("a_write_unexpected", int'(addr_a), -1);
         else begin
            e = qa.pop_front();
            check("a_addr", int'(addr_a), e.addr);
            check("a_pixel", int'(pix_a), e.data);
         end
      end
      if (we_b) begin
         if (qb.size() == 0) check("b_write_unexpected", int'(addr_b), -1);
         else begin
            e = qb.pop_front();
            check("b_addr", int'(addr_b), e.addr);
            check("b_pixel", int'(pix_b), e.data);
         end
      end
      if (fd_a) fd_cnt[0]++;
      if (fd_b) fd_cnt[1]++;
   end

   // Reference pixel: decode the camera colour, then keep the top bits of each channel.
   function automatic int ref_pixel(input int md, input logic [7:0] b0, input logic [7:0] b1,
                                    input int kx, input int w);
      logic [4:0] r, bl;
      logic [5:0] g;
      int bar;
      if (md == 1) return int'({b0[7:5], b0[7:5], b0[7:6]});
      if (md == 2) begin
         bar = kx / (w / 8);
         return (bar < 8) ? int'(bars[bar]) : 0;
      end
      r = b0[7:3]; g = {b0[2:0], b1[7:5]}; bl = b1[4:0];
      return int'({r[4:2], g[5:3], bl[4:3]});
   endfunction

   task automatic model(input int d, input int nl, input int md, input int cap,
                        input int ab_line, input int ab_byte, output bit ovf_e, output int nwr);
      int w, xs, ys, ky, kx, nb;
      bit wrote;
      exp_t e;
      w = d ? 8 : 16; xs = d ? 2 : 1; ys = d ? 2 : 1;
      ovf_e = 0; nwr = 0; ky = 0;
      if (cap == 0) return;
      for (int li = 0; li < nl; li++) begin
         if (ab_line >= 0 && li > ab_line) break;
         nb = (li == ab_line) ? ab_byte : lens[li];
         if (li % ys != 0) continue;
         kx = 0; wrote = 0;
         for (int p = 0; p < nb / 2; p++) begin
            if (p % xs != 0) continue;
            if (kx < w && ky < 4) begin
               e.addr = ky * w + kx;
               e.data = ref_pixel(md, fb[li][2*p], fb[li][2*p+1], kx, w);
               if (d != 0) qb.push_back(e); else qa.push_back(e);
               nwr++; wrote = 1;
            end else ovf_e = 1;
            kx++;
         end
         if (wrote) ky++;
      end
      if (nwr > 0) fd_exp[d]++;
   endtask

   task automatic fill(input int nl, input int len, input int pair);
      for (int li = 0; li < nl; li++) begin
         lens[li] = (len == 0) ? $urandom_range(4, 44) : len;
         for (int b = 0; b < 48; b++)
            fb[li][b] = (pair < 0) ? 8'($urandom) : ((b % 2) ? pair[7:0] : pair[15:8]);
      end
   endtask

   task automatic drive_frame(input int nl, input int md, input int cap, input int ab_line, input int ab_byte);
      vsync = 1'b1; href = 1'b0; mode = md[1:0]; cap_en = cap[0];
      repeat (4) tick();
      vsync = 1'b0;
      repeat (3) tick();
      check("busy_a", int'(busy_a), cap);
      check("busy_b", int'(busy_b), cap);
      mode = 2'($urandom); cap_en = 1'($urandom);   // must be ignored until the next frame
      for (int li = 0; li < nl; li++) begin
         href = 1'b1;
         for (int b = 0; b < lens[li]; b++) begin
            cam = fb[li][b];
            if (li == ab_line && b == ab_byte) vsync = 1'b1;
            tick();
         end
         href = 1'b0; cam = 8'($urandom);
         repeat (3) tick();
         if (li == ab_line) break;
      end
      vsync = 1'b1;
      repeat (4) tick();
   endtask

   task automatic run_frame(input string tag, input int nl, input int md, input int cap,
                            input int ab_line, input int ab_byte);
      bit oa, ob;
      int na, nb;
      model(0, nl, md, cap, ab_line, ab_byte, oa, na);
      model(1, nl, md, cap, ab_line, ab_byte, ob, nb);
      drive_frame(nl, md, cap, ab_line, ab_byte);
      repeat (3) tick();
      check({tag, "_a_pending"}, qa.size(), 0);
      check({tag, "_b_pending"}, qb.size(), 0);
      check({tag, "_a_frame_done"}, fd_cnt[0], fd_exp[0]);
      check({tag, "_b_frame_done"}, fd_cnt[1], fd_exp[1]);
      check({tag, "_a_ovf"}, int'(ovf_a), int'(oa));
      check({tag, "_b_ovf"}, int'(ovf_b), int'(ob));
      $display("[TB] frame %s mode=%0d cap=%0d lines=%0d writes a=%0d b=%0d ovf a=%0d b=%0d",
               tag, md, cap, nl, na, nb, oa, ob);
      qa.delete(); qb.delete();
      fd_cnt[0] = fd_exp[0]; fd_cnt[1] = fd_exp[1];
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0; tick();
      if (oa) check({tag, "_a_ovf_clear"}, int'(ovf_a), 0);
      if (ob) check({tag, "_b_ovf_clear"}, int'(ovf_b), 0);
   endtask

   initial begin
      int nl, md, cap, ab_line, ab_byte, na, nb, sv0, sv1;
      bit oa, ob;
      rst = 1'b1; href = 1'b0; vsync = 1'b0; cam = '0; mode = '0; cap_en = 1'b1; clr_ovf = 1'b0;
      repeat (3) tick();
      check("reset_a", int'({we_a, addr_a, pix_a, fd_a, busy_a, ovf_a}), 0);
      check("reset_b", int'({we_b, addr_b, pix_b, fd_b, busy_b, ovf_b}), 0);
      rst = 1'b0;
      tick();

      fill(4, 32, 'hF800); run_frame("rgb_fill", 4, 0, 1, -1, 0);
      fill(8, 32, 'h8055); run_frame("gray_dec", 8, 1, 1, -1, 0);
      fill(4, 32, -1);     run_frame("bars", 4, 2, 1, -1, 0);
      fill(1, 40, -1);     run_frame("long_line", 1, 3, 1, -1, 0);
      fill(3, 20, -1);     run_frame("skip", 3, 0, 0, -1, 0);
      fill(2, 15, -1);     run_frame("odd_bytes", 2, 0, 1, -1, 0);
      fill(3, 24, -1);     run_frame("vs_abort", 3, 1, 1, 1, 10);

      // Reset in the gap after the first line: only that line may write, then nothing until a new VSYNC cycle.
      fill(2, 24, -1);
      sv0 = fd_exp[0]; sv1 = fd_exp[1];
      model(0, 1, 0, 1, -1, 0, oa, na);
      model(1, 1, 0, 1, -1, 0, ob, nb);
      fd_exp[0] = sv0; fd_exp[1] = sv1;
      vsync = 1'b1; mode = 2'd0; cap_en = 1'b1;
      repeat (4) tick();
      vsync = 1'b0;
      repeat (3) tick();
      href = 1'b1;
      for (int b = 0; b < lens[0]; b++) begin cam = fb[0][b]; tick(); end
      href = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      check("midreset_a", int'({we_a, addr_a, pix_a, fd_a, busy_a, ovf_a}), 0);
      check("midreset_b", int'({we_b, addr_b, pix_b, fd_b, busy_b, ovf_b}), 0);
      rst = 1'b0;
      tick();
      href = 1'b1;
      for (int b = 0; b < lens[1]; b++) begin cam = fb[1][b]; tick(); end
      href = 1'b0;
      repeat (4) tick();
      check("midreset_a_pending", qa.size(), 0);
      check("midreset_b_pending", qb.size(), 0);
      $display("[TB] frame midreset writes a=%0d b=%0d", na, nb);
      qa.delete(); qb.delete();

      fill(4, 32, 'hF800); run_frame("after_reset", 4, 0, 1, -1, 0);

      for (int f = 0; f < 20; f++) begin
         nl  = $urandom_range(1, 7);
         md  = $urandom_range(0, 3);
         cap = ($urandom_range(0, 4) != 0) ? 1 : 0;
         fill(nl, 0, -1);
         ab_line = -1; ab_byte = 0;
         if ($urandom_range(0, 4) == 0) begin
            ab_line = $urandom_range(0, nl - 1);
            ab_byte = 2 * $urandom_range(0, (lens[ab_line] - 2) / 2);
         end
         run_frame($sformatf("rand%0d", f), nl, md, cap, ab_line, ab_byte);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/cam_capture_ds.md
Name: cam_capture_ds

Overview:
- Parametrised camera capture/downsampler for the OV7670 path; successor to the fixed RGB565→RGB332 downsampler.
- Clocked by the camera pixel clock. Decodes VSYNC/HREF framing and assembles 2-byte pixels.
- Supports runtime-selectable output mode (RGB332, grayscale from YUV, colour-bar test pattern) and power-of-two decimation in X and Y.
- Produces M9K write strobes, linear addresses, frame-done pulses and overflow status. Sits between the camera GPIO pins and Dual_Port_RAM_M9K's write port.

Parameters:
WIDTH, 176, stored frame width in pixels
HEIGHT, 144, stored frame height in lines
ADDR_W, 15, write address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
XDEC_LOG2, 0, keep 1 of every 2^XDEC_LOG2 camera pixels per line (0..3)
YDEC_LOG2, 0, keep 1 of every 2^YDEC_LOG2 camera lines (0..3)

Ports:
CLOCK  input  1  camera pixel clock (PCLK); all logic on rising edge
RESET  input  1  asynchronous, active-high reset
CAMERA_IN  input  8  camera data byte
HREF  input  1  high = active line bytes
VSYNC  input  1  high = vertical blanking
MODE  input  2  0 RGB332 from RGB565; 1 gray from YUYV; 2 colour bars; 3 reserved (behaves as 0)
CAPTURE_EN  input  1  sampled at frame start; 0 = skip (freeze) that frame
CLR_OVF  input  1  one-cycle pulse clears OVF
W_EN  output  1  one-cycle write strobe
W_ADDR  output  ADDR_W  linear address x + y*WIDTH
PIXEL_OUT  output  8  RGB332 pixel
FRAME_DONE  output  1  one-cycle pulse at end of a captured frame
BUSY  output  1  high while a frame is being captured
OVF  output  1  sticky: pixel or line dropped because it fell outside WIDTH/HEIGHT

Behaviour:
- Reset: all outputs 0; state WAIT_VS; counters, byte phase and MODE latch cleared.
- VSYNC, HREF and CAMERA_IN are registered once. All decisions below use the registered copies.
- FSM states:
  - WAIT_VS: wait for VSYNC=1 → VBLANK. This discards any partial frame after reset.
  - VBLANK: on VSYNC falling edge → ACTIVE if CAPTURE_EN=1, else SKIP. MODE and CAPTURE_EN are latched here; mid-frame changes are ignored. Line base, y, camera line counter and bar state are cleared.
  - ACTIVE: BUSY=1. On VSYNC rising edge → VBLANK and FRAME_DONE=1 for 1 cycle, only if at least one write occurred in the frame.
  - SKIP: no writes, no FRAME_DONE. On VSYNC rising edge → VBLANK.
- Byte phase: cleared on every HREF rising edge and whenever HREF=0.
  - Phase 0: latch byte.
  - Phase 1: form pixel, increment camera pixel counter.
  - HREF falling on phase 1 (odd byte count) discards the partial byte.
- Pixel formation:
  - MODE 0: b0={R4..R0,G5..G3}, b1={G2..G0,B4..B0}; out={R4:R2,G5:G3,B4:B3}.
  - MODE 1: Y = b0; out={Y7:Y5,Y7:Y5,Y7:Y6}.
  - MODE 2: bytes ignored; 8 vertical bars, each WIDTH>>3 stored pixels wide (bar counter, no divider). Colours in order: FF, FC, 1F, 1C, E3, E0, 03, 00. Any remainder pixels repeat 00.
- Decimation:
  - A pixel is kept when camera pixel count mod 2^XDEC_LOG2 == 0.
  - A line is kept when camera line count mod 2^YDEC_LOG2 == 0.
  - The camera line counter increments on HREF falling.
- Write:
  - A kept pixel with x<WIDTH and y<HEIGHT drives W_EN=1, PIXEL_OUT and W_ADDR registered together, one cycle after the phase-1 byte is registered.
  - Latency from the second byte at the pin to W_EN is 2 CLOCK cycles.
  - x increments per kept pixel.
  - At the end of a kept line that wrote ≥1 pixel, y increments and line base += WIDTH. No multiplier; W_ADDR = line base + x.
- Clipping:
  - Kept pixel with x≥WIDTH, or kept line with y≥HEIGHT: no write, OVF←1.
  - OVF stays set until RESET or CLR_OVF. If CLR_OVF and a new overflow occur in the same cycle, set wins.
- VSYNC rising while HREF=1: VSYNC wins; the line is aborted and no further writes occur.
- W_EN is never asserted when VSYNC=1 or outside ACTIVE.
- RESET mid-frame: immediate clear and return to WAIT_VS. The next write occurs only after a full VSYNC high→low cycle.

Test Plan:
- WIDTH=8, HEIGHT=4, MODE 0. Frame: 4 lines × 16 bytes, byte pairs (F8,00) → 32 writes, PIXEL_OUT=E0, W_ADDR 0..31 in order, one FRAME_DONE on VSYNC rise, OVF=0.
- MODE 1, XDEC_LOG2=1, YDEC_LOG2=1, camera 16 px × 8 lines, Y byte=0x80, chroma 0x55 → 32 writes, PIXEL_OUT=92, addresses 0..31.
- MODE 2, WIDTH=16 → per line, pixel pairs read FF,FF,FC,FC,1F,1F,1C,1C,E3,E3,E0,E0,03,03,00,00; camera bytes ignored.
- Line of 20 pixels with WIDTH=8 → 8 writes, then OVF=1. CLR_OVF pulse → OVF=0. Extra 5th line with HEIGHT=4 → no write, OVF=1.
- CAPTURE_EN=0 at VSYNC fall → zero W_EN, no FRAME_DONE, BUSY=0. Next frame with CAPTURE_EN=1 → captures normally.
- Odd byte count (15) on a line → 7 writes. Separately: VSYNC rise mid-line → writes stop. RESET mid-frame → outputs 0, no writes until after the next VSYNC high→low.
